// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flop, LSB first,
// with a start/busy/done handshake and carry-out / signed-overflow flags.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic s_bit;
  logic cn_bit;

  // The single full-adder cell shared by every bit position.
  assign s_bit  = opa_q[0] ^ opb_q[0] ^ c_q;
  assign cn_bit = (opa_q[0] & opb_q[0]) | (c_q & (opa_q[0] ^ opb_q[0]));

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          // Subtraction is a + ~b + 1: invert b and seed the carry with 1.
          opa_d   = a;
          opb_d   = sub ? ~b : b;
          c_d     = sub;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d = {s_bit, sum_q[WIDTH-1:1]};
        opa_d = opa_q >> 1;
        opb_d = opb_q >> 1;
        c_d   = cn_bit;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          // c_q here is the carry into the MSB; overflow when it differs from carry out.
          cout_d  = cn_bit;
          ovf_d   = c_q ^ cn_bit;
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub: 8-bit add/sub/handshake cases plus an
// exhaustive 2-bit sweep with start held high.
module tb_serial_addsub;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, sub8;
  logic [7:0] a8, b8;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;
  logic       start2, sub2;
  logic [1:0] a2, b2;
  logic       busy2, done2, cout2, ovf2;
  logic [1:0] sum2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_addsub #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .sub(sub2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One 8-bit operation: busy for 8 cycles after the start edge, then a done pulse.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s,
                      input logic [7:0] exp_sum, input logic exp_cout, input logic exp_ovf);
    a8 = a; b8 = b; sub8 = s; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    a8 = ~a; b8 = ~b; sub8 = ~s;
    for (int i = 0; i < 8; i++) begin
      check("busy8_run", 32'(busy8), 32'd1);
      check("done8_run", 32'(done8), 32'd0);
      tick();
    end
    check("busy8_done", 32'(busy8), 32'd0);
    check("done8_pulse", 32'(done8), 32'd1);
    check("sum8", 32'(sum8), 32'(exp_sum));
    check("cout8", 32'(cout8), 32'(exp_cout));
    check("ovf8", 32'(ovf8), 32'(exp_ovf));
    $display("op8 a=%02h b=%02h sub=%0d -> sum=%02h cout=%0d ovf=%0d", a, b, s, sum8, cout8, ovf8);
    tick();
    check("done8_clear", 32'(done8), 32'd0);
  endtask

  initial begin
    int         ndone;
    logic [7:0] cap;
    logic [1:0] bv;
    logic [2:0] tot;
    logic       ev;

    rst = 1'b1;
    start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
    start2 = 1'b0; sub2 = 1'b0; a2 = '0; b2 = '0;
    repeat (3) tick();
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_sum", 32'(sum8), 32'd0);
    check("rst_cout", 32'(cout8), 32'd0);
    check("rst_ovf", 32'(ovf8), 32'd0);
    check("rst_busy2", 32'(busy2), 32'd0);
    rst = 1'b0;
    tick();

    run8(8'h35, 8'h1C, 1'b0, 8'h51, 1'b0, 1'b0);
    run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run8(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
    run8(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

    // Start pulse on the 3rd busy cycle must be ignored.
    a8 = 8'h05; b8 = 8'h03; sub8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    ndone = 0;
    cap = 8'h00;
    for (int i = 0; i < 14; i++) begin
      if (i == 2) begin
        start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
      end
      if (i == 3) start8 = 1'b0;
      if (done8) begin
        ndone++;
        cap = sum8;
      end
      tick();
    end
    check("ign_done_count", 32'(ndone), 32'd1);
    check("ign_sum", 32'(cap), 32'h08);
    check("ign_idle", 32'(busy8), 32'd0);
    $display("op8 a=05 b=03 with ignored start -> sum=%02h done_pulses=%0d", cap, ndone);

    // Reset on the 4th RUN cycle aborts the operation.
    a8 = 8'h35; b8 = 8'h1C; sub8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (3) tick();
    check("abort_busy_before", 32'(busy8), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 32'(busy8), 32'd0);
    check("abort_done", 32'(done8), 32'd0);
    check("abort_sum", 32'(sum8), 32'd0);
    check("abort_cout", 32'(cout8), 32'd0);
    check("abort_ovf", 32'(ovf8), 32'd0);
    $display("op8 a=35 b=1C aborted by reset -> sum=%02h", sum8);
    run8(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

    // Exhaustive 2-bit sweep, start held high throughout.
    start2 = 1'b1;
    for (int op = 0; op < 32; op++) begin
      a2 = op[1:0]; b2 = op[3:2]; sub2 = op[4];
      bv  = sub2 ? ~b2 : b2;
      tot = {1'b0, a2} + {1'b0, bv} + {2'b00, sub2};
      ev  = (a2[1] == bv[1]) && (tot[1] != a2[1]);
      tick();
      check("w2_busy", 32'(busy2), 32'd1);
      a2 = ~a2; b2 = ~b2; sub2 = ~sub2;
      tick();
      tick();
      check("w2_done", 32'(done2), 32'd1);
      check("w2_sum", 32'(sum2), 32'(tot[1:0]));
      check("w2_cout", 32'(cout2), 32'(tot[2]));
      check("w2_ovf", 32'(ovf2), 32'(ev));
      if (op < 16) begin
        check("w2_ha_bit0", 32'(sum2[0]), 32'(op[0] ^ op[2]));
        check("w2_ha_bit1", 32'(sum2[1]), 32'(op[1] ^ op[3] ^ (op[0] & op[2])));
      end
      $display("op2 a=%0d b=%0d sub=%0d -> sum=%0d cout=%0d ovf=%0d",
               op[1:0], op[3:2], op[4], sum2, cout2, ovf2);
      tick();
      check("w2_done_clear", 32'(done2), 32'd0);
    end
    start2 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
Parametrised bit-serial adder/subtractor built around a single full-adder cell and a carry flip-flop. It generalises our half-adder gate pair to WIDTH-bit operands, an add/subtract mode, signed-overflow detection and a start/busy/done handshake. It processes one bit per clock, LSB first. It is used as the shared arithmetic unit in lab datapaths where area matters more than latency.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request pulse; sampled only in IDLE
sub  input  1  0 = a+b, 1 = a-b; sampled with start
a  input  WIDTH  operand A; sampled with start
b  input  WIDTH  operand B; sampled with start
busy  output  1  high while bits are being processed (RUN)
done  output  1  one-cycle pulse: result valid
sum  output  WIDTH  result register
cout  output  1  carry out of MSB (for subtract: 1 = no borrow)
ovf  output  1  signed (two's-complement) overflow

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0.
  - Internal operand registers, carry and bit counter are cleared.
  - rst has priority over everything, including start at the same edge.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge k:
  - Latch opa=a and opb = sub ? ~b : b.
  - Carry flop c = sub.
  - Counter = 0; go to RUN.
  - sum, cout and ovf keep their previous values until overwritten.
- RUN, edges k+1 .. k+WIDTH, one bit per edge:
  - s = opa[0]^opb[0]^c; cn = (opa[0]&opb[0]) | (c&(opa[0]^opb[0])).
  - sum shifts right with s entering the MSB; opa and opb shift right; c = cn; counter increments.
  - At the edge that processes the MSB (counter = WIDTH-1):
    - Additionally capture cin_msb, the carry into the MSB (the c value before the update).
    - cout = cn; ovf = cin_msb ^ cn; go to DONE.
  - busy=1 throughout RUN. It is registered, so it is high for cycles k+1..k+WIDTH after edge k.
- DONE: done=1 for exactly one cycle, busy=0; next edge goes to IDLE.
- Latency: start sampled at edge k, done observed high after edge k+WIDTH+... precisely: done is high in the cycle between edges k+WIDTH and k+WIDTH+1. Total WIDTH+1 cycles from start to done.
- Throughput: a new start is accepted at the earliest in the cycle after done, i.e. in IDLE.
- Boundary conditions:
  - start in RUN or DONE: ignored, and the sampled a/b/sub are discarded.
  - start held high continuously: back-to-back operations, each separated by the DONE cycle plus one IDLE sample.
  - Operand inputs may change freely after the start edge without affecting the result.
  - Wrap-around: results are modulo 2^WIDTH; cout/ovf report the out-of-range cases.
  - rst mid-RUN aborts the operation: outputs go to reset values and the partial sum is lost; the next start works normally.
- Counter width: clog2(WIDTH); no combinational path from inputs to outputs.

Test Plan:
- WIDTH=8, a=0x35, b=0x1C, sub=0, start at edge k -> busy high for 8 cycles; done high in cycle after edge k+8; sum=0x51, cout=0, ovf=0.
- a=0xFF, b=0x01, sub=0 -> sum=0x00, cout=1, ovf=0. Then a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1.
- sub=1: a=0x10, b=0x20 -> sum=0xF0, cout=0 (borrow), ovf=0. Then a=0x80, b=0x01 -> sum=0x7F, cout=1, ovf=1.
- Start 0x05+0x03, then pulse start with a=0xAA, b=0x55 on the 3rd busy cycle -> second request ignored; sum=0x08; done pulses exactly once.
- rst=1 on the 4th RUN cycle of 0x35+0x1C -> next cycle busy=0, done=0, sum=0x00, cout=0, ovf=0. A subsequent start with 0x01+0x01 -> sum=0x02 after 9 cycles.
- WIDTH=2, exhaustive 16 add and 16 subtract cases, start held high -> each result matches modulo 4 with correct cout/ovf. Bit 0 of every add equals a[0]^b[0], with carry a[0]&b[0] (half-adder consistency).
